// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM state encoding, data width, baud divider.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// 2-FF synchronizer with a previous-value register; reports the synchronized level and falling edges.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic line_o,
    output logic fall_o
);

    logic       meta_q;
    logic       line_q;
    logic       prev_q;
    logic [1:0] fill_q;

    // prev_q only takes values that came from the pin, so a line held low through reset
    // release never looks like a 1->0 transition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            line_q <= 1'b1;
            prev_q <= 1'b0;
            fill_q <= '0;
        end else begin
            meta_q <= async_i;
            line_q <= meta_q;
            fill_q <= {fill_q[0], 1'b1};
            prev_q <= fill_q[1] & line_q;
        end
    end

    assign line_o = line_q;
    assign fall_o = prev_q & ~line_q;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 3-sample majority per bit, framed bytes on valid/ready.
// Define UART_RX_PARITY_EN for an even-parity bit and the rx_parity_err output.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 12_000_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DIV    = uart_div(CLK_HZ, BAUD)
) (
    input  logic                   CLK_12MHZ,
    input  logic                   RST_N,
    input  logic                   UART_RX,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   rx_frame_err,
    output logic                   rx_overrun,
`ifdef UART_RX_PARITY_EN
    output logic                   rx_parity_err,
`endif
    output logic                   rx_busy
);

    if (DIV < 8) begin : g_div_check
        $error("uart_rx_deser: DIV must be at least 8");
    end

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] SMP0    = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] SMP1    = CW'(DIV / 2);
    localparam logic [CW-1:0] SMP2    = CW'(DIV / 2 + 1);

    uart_rx_state_t         state_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bitidx_q, bitidx_d;
    logic                   s0_q, s1_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic [UART_DATA_W-1:0] data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   ovr_q;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q;
    logic                   perr_q;
`endif

    logic line;
    logic fall;
    logic maj;
    logic decide;

    uart_rx_sync u_sync (
        .clk_i  (CLK_12MHZ),
        .rst_ni (RST_N),
        .async_i(UART_RX),
        .line_o (line),
        .fall_o (fall)
    );

    assign maj    = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);
    assign decide = (cnt_q == SMP2);

    // Timer is held at zero in IDLE so the edge-detect cycle starts the start bit at cnt 0.
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        bitidx_d = bitidx_q;
        if (state_q == IDLE) begin
            cnt_d    = '0;
            bitidx_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d    = '0;
            bitidx_d = bitidx_q + 4'd1;
        end
    end

    always_ff @(posedge CLK_12MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitidx_q  <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
            if (cnt_q == SMP0) s0_q <= line;
            if (cnt_q == SMP1) s1_q <= line;
            if (valid_q && rx_ready) valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (fall) state_q <= START;
                end
                START: begin
                    if (decide) state_q <= maj ? IDLE : DATA;
                end
                DATA: begin
                    if (decide) begin
                        shift_q <= {maj, shift_q[UART_DATA_W-1:1]};
                        if (bitidx_q == 4'd8) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decide) begin
                        par_bad_q <= maj ^ (^shift_q);
                        state_q   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (decide) begin
                        if (maj) begin
`ifdef UART_RX_PARITY_EN
                            perr_q <= par_bad_q;
`endif
                            // A commit in the acceptance cycle overrides the clear above.
                            if (!valid_q || rx_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (line) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`endif
    assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at 12 MHz / 115200 (DIV = 104); follows UART_RX_PARITY_EN.
module tb_uart_rx_deser;

    localparam int DIV = 104;
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 11;
    localparam int LAT = 1097;
    localparam int FRM = 1144;
`else
    localparam int NB  = 10;
    localparam int LAT = 993;
    localparam int FRM = 1040;
`endif

    logic       clk;
    logic       RST_N;
    logic       UART_RX;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    uart_rx_deser #(.CLK_HZ(12_000_000), .BAUD(115200)) dut (
        .CLK_12MHZ    (clk),
        .RST_N        (RST_N),
        .UART_RX      (UART_RX),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
`ifdef UART_RX_PARITY_EN
        .rx_parity_err(rx_parity_err),
`endif
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_valid = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
    int         t_last = 0, t_prev = 0, t_ferr = 0, t_ovr = 0;
    logic       pv = 1'b0;
    logic [7:0] dq[$];

    always @(negedge clk) begin
        if (rx_valid && !pv) begin
            n_valid <= n_valid + 1;
            dq.push_back(rx_data);
            t_prev  <= t_last;
            t_last  <= cyc;
        end
        pv <= rx_valid;
        if (rx_frame_err) begin
            n_ferr <= n_ferr + 1;
            t_ferr <= cyc;
        end
        if (rx_overrun) begin
            n_ovr <= n_ovr + 1;
            t_ovr <= cyc;
        end
`ifdef UART_RX_PARITY_EN
        if (rx_parity_err) n_perr <= n_perr + 1;
`endif
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        UART_RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            UART_RX = bits[i];
            repeat (DIV) @(negedge clk);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
        return {stop, ^d, d, 1'b0};
`else
        return {1'b0, stop, d, 1'b0};
`endif
    endfunction

    int c0, bv, bf, bo, bp;

    initial begin
        RST_N    = 1'b0;
        UART_RX  = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(rx_data),      32'h0);
        check("rst_valid", 32'(rx_valid),     32'h0);
        check("rst_ferr",  32'(rx_frame_err), 32'h0);
        check("rst_ovr",   32'(rx_overrun),   32'h0);
        check("rst_busy",  32'(rx_busy),      32'h0);
        RST_N = 1'b1;
        idle(20);

        // back-to-back 0x55, 0xA3
        bv = n_valid; bf = n_ferr; bo = n_ovr;
        c0 = cyc;
        send_bits(frame(8'h55, 1'b1), NB);
        send_bits(frame(8'hA3, 1'b1), NB);
        idle(20);
        check("b2b_count",   32'(n_valid - bv), 32'd2);
        check("b2b_data0",   32'(dq[bv]),       32'h55);
        check("b2b_data1",   32'(dq[bv + 1]),   32'hA3);
        check("b2b_latency", 32'(t_prev - c0),  32'(LAT));
        check("b2b_spacing", 32'(t_last - t_prev), 32'(FRM));
        check("b2b_ferr",    32'(n_ferr - bf),  32'd0);
        check("b2b_ovr",     32'(n_ovr - bo),   32'd0);

        // 20-cycle glitch
        bv = n_valid; bf = n_ferr;
        UART_RX = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy", 32'(rx_busy), 32'd1);
        repeat (10) @(negedge clk);
        idle(2 * DIV);
        check("glitch_idle",  32'(rx_busy),        32'd0);
        check("glitch_valid", 32'(n_valid - bv),   32'd0);
        check("glitch_ferr",  32'(n_ferr - bf),    32'd0);

        // stop bit low, line low for another bit time, then 0x81
        bv = n_valid; bf = n_ferr;
        c0 = cyc;
        send_bits(frame(8'h3C, 1'b0), NB);
        repeat (DIV) @(negedge clk);
        idle(2 * DIV);
        check("ferr_count",   32'(n_ferr - bf),  32'd1);
        check("ferr_time",    32'(t_ferr - c0),  32'(LAT));
        check("ferr_novalid", 32'(n_valid - bv), 32'd0);
        send_bits(frame(8'h81, 1'b1), NB);
        idle(20);
        check("after_ferr_count", 32'(n_valid - bv), 32'd1);
        check("after_ferr_data",  32'(rx_data),      32'h81);

        // overrun with consumer stalled
        bv = n_valid; bo = n_ovr;
        rx_ready = 1'b0;
        send_bits(frame(8'h11, 1'b1), NB);
        send_bits(frame(8'h22, 1'b1), NB);
        idle(20);
        check("ovr_rises", 32'(n_valid - bv),  32'd1);
        check("ovr_valid", 32'(rx_valid),      32'd1);
        check("ovr_data",  32'(rx_data),       32'h11);
        check("ovr_count", 32'(n_ovr - bo),    32'd1);
        check("ovr_time",  32'(t_ovr - t_last), 32'(FRM));
        rx_ready = 1'b1;
        @(negedge clk);
        check("ovr_accept_valid", 32'(rx_valid), 32'd0);
        check("ovr_accept_data",  32'(rx_data),  32'h11);

        // reset during bit 4 of 0xF0
        UART_RX = 1'b0;
        repeat (5 * DIV) @(negedge clk);
        UART_RX = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        check("midrst_busy_before", 32'(rx_busy), 32'd1);
        RST_N = 1'b0;
        #1;
        check("midrst_data",  32'(rx_data),      32'h0);
        check("midrst_valid", 32'(rx_valid),     32'h0);
        check("midrst_busy",  32'(rx_busy),      32'h0);
        check("midrst_ferr",  32'(rx_frame_err), 32'h0);
        repeat (3) @(negedge clk);
        RST_N = 1'b1;
        idle(6 * DIV);
        bv = n_valid; bf = n_ferr;
        send_bits(frame(8'h0F, 1'b1), NB);
        idle(20);
        check("postrst_count", 32'(n_valid - bv), 32'd1);
        check("postrst_data",  32'(rx_data),      32'h0F);
        check("postrst_ferr",  32'(n_ferr - bf),  32'd0);

        // reset released while the line is still low
        bv = n_valid; bf = n_ferr;
        UART_RX = 1'b0;
        repeat (30) @(negedge clk);
        RST_N = 1'b0;
        repeat (3) @(negedge clk);
        RST_N = 1'b1;
        repeat (150) @(negedge clk);
        check("lowrst_busy", 32'(rx_busy), 32'd0);
        repeat (150) @(negedge clk);
        idle(2 * DIV);
        check("lowrst_valid", 32'(n_valid - bv), 32'd0);
        check("lowrst_ferr",  32'(n_ferr - bf),  32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1
        bv = n_valid; bp = n_perr;
        send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        idle(20);
        check("par_bad_count", 32'(n_valid - bv), 32'd1);
        check("par_bad_data",  32'(rx_data),      32'h07);
        check("par_bad_perr",  32'(n_perr - bp),  32'd1);
        bv = n_valid; bp = n_perr;
        send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
        idle(20);
        check("par_ok_count", 32'(n_valid - bv), 32'd1);
        check("par_ok_data",  32'(rx_data),      32'h07);
        check("par_ok_perr",  32'(n_perr - bp),  32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
